predecode_queue: RTL
====================

Name: predecode_queue

Overview:
Instruction buffer placed between the fetch and decode stages of the MIPS pipeline. It accepts up to IN_WIDTH instructions per cycle from fetch. At push time it predecodes each instruction into the 13-bit main control word and the exception flags (reserved instruction, syscall, break, eret), plus a delay-slot flag. Decode pops one predecoded entry per cycle through a valid/ready handshake. A flush discards all buffered work.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2*IN_WIDTH
IN_WIDTH, 2, instructions accepted per push (1 or 2)
CP0_EN, 1, 1: MFC0/MTC0/ERET are legal; 0: they raise reserved-instruction (ERET gives eret=0, ri=1)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  exception/redirect flush; empties the queue
in_valid  in  IN_WIDTH  per-lane valid; lanes contiguous from lane 0 (e.g. 2'b10 is illegal)
in_instr  in  32*IN_WIDTH  lane k = bits [32k+31:32k]; lane 0 is oldest
in_pc  in  32*IN_WIDTH  PC per lane
in_ready  out  1  (DEPTH - count) >= IN_WIDTH
out_valid  out  1  count != 0
out_ready  in  1  decode accepts head entry
out_instr  out  32  head instruction
out_pc  out  32  head PC
out_ctrl  out  13  [12] reg_write, [11:10] reg_dst (00 rt, 01 rd, 10 r31), [9] alu_src_pc, [8] alu_src_imm, [7:6] write_src (00 alu, 01 mem, 10 cp0), [5] hilo_read, [4] hilo_write, [3] branch, [2] unsigned_ext, [1] jump, [0] cp0_write
out_ri, out_syscall, out_break, out_eret  out  1 each  head exception flags
out_in_ds  out  1  head entry sits in a branch/jump delay slot
count  out  $clog2(DEPTH+1)  occupancy

Behaviour:
- Reset: rd_ptr = wr_ptr = 0, count = 0, last_br = 0. in_ready = 1. out_valid = 0.
- When count == 0, all out_* data/flag outputs are forced to 0. Storage RAM is not reset.
- Push fires when in_ready && |in_valid && !flush. Writes popcount(in_valid) entries at wr_ptr, wr_ptr+1 (mod DEPTH), in lane order.
- Pop fires when out_valid && out_ready && !flush. rd_ptr advances by 1 (mod DEPTH).
- Simultaneous push and pop: count += pushed - 1. in_ready does not credit the same-cycle pop (no bypass). Empty-queue push becomes visible at out_* the next cycle (latency 1).
- Flush has priority over push and pop. Next cycle: count = 0, rd_ptr = wr_ptr, last_br = 0. Instructions presented in the flush cycle are dropped.
- Predecode (combinational per lane, stored with the entry):
  - R-type: MTHI/MTLO 0x0030; MFHI/MFLO 0x1420; MULT/MULTU/DIV/DIVU 0x1410.
  - JR 0x0002, ri if instr[20:6] != 0.
  - JALR 0x1602, ri if rt != 0 or sa != 0.
  - Other R-type 0x1400.
  - ADDI/ADDIU/SLTI/SLTIU 0x1100; ANDI/ORI/XORI/LUI 0x1104.
  - Loads 0x1140; stores 0x0100.
  - BEQ/BNE 0x0008; BGTZ/BLEZ 0x0008, ri if rt != 0.
  - REGIMM: BLTZ/BGEZ 0x0008; BLTZAL/BGEZAL 0x1A08; other rt -> ri.
  - J 0x0002; JAL 0x1A02.
  - COP0 (CP0_EN=1): MFC0 0x1080; MTC0 0x0001; ERET (exactly 0x42000018) eret=1; other rs -> ri.
  - Any other opcode -> ri.
  - Every ri case forces ctrl = 0.
  - syscall/break: SPECIAL with funct 0x0C/0x0D.
- Delay slot: in_ds of an entry = branch|jump of the immediately preceding pushed instruction. That is lane 0 of the same push for lane 1; otherwise last_br. last_br updates to branch|jump of the last lane pushed.
- Illegal in_valid patterns are undefined and must be flagged by a bench assertion.

Decomposition:
- Package mips_defs_pkg: opcode/funct/rt/rs constants, ERET encoding, control-word field bit positions.
- Sub-module ctrl_predecode: combinational, instr -> {ctrl, ri, syscall, break, eret, br_or_j}, parameter CP0_EN. Instantiated IN_WIDTH times.
- The queue and pointer logic stay in predecode_queue.

Test Plan:
- Reset, then push lane0 0x24080005 (ADDIU) -> next cycle out_valid=1, out_ctrl=0x1100, all flags 0, count=1.
- Push {0x10000003 BEQ, 0x00000000 NOP} -> BEQ ctrl=0x0008, in_ds=0; NOP ctrl=0x1400, in_ds=1. Repeat with BEQ and NOP in separate pushes -> same result via last_br.
- Push 0x0000000C, 0x42000018, 0xFC000000, 0x03E10008 -> syscall=1 (ctrl 0x1400); eret=1 ri=0; ri=1 ctrl=0; ri=1 ctrl=0. With CP0_EN=0, 0x42000018 -> ri=1, eret=0.
- Fill to DEPTH with out_ready=0 -> in_ready=0 at count>DEPTH-IN_WIDTH, no overwrite. Drain -> entries in order across pointer wrap.
- Assert flush together with push and pop at count=5 -> next cycle count=0, out_valid=0, out_in_ds of the next pushed instruction=0.
- Assert rst mid-stream (asynchronous, mid-cycle) -> count=0 and out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// Shared MIPS encodings and predecode types for the fetch/decode instruction buffer.
// Control words are listed as complete constants so each instruction class reads as one line.
package mips_defs_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_SYSCALL = 6'h0C, FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO    = 6'h12, FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV     = 6'h1A, FN_DIVU  = 6'h1B;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04;

  localparam logic [31:0] INSTR_ERET = 32'h4200_0018;

  // Control word field positions (two-bit fields give their low bit).
  localparam int CB_REG_WRITE = 12, CB_REG_DST = 10, CB_ALU_SRC_PC = 9, CB_ALU_SRC_IMM = 8;
  localparam int CB_WRITE_SRC = 6, CB_HILO_READ = 5, CB_HILO_WRITE = 4, CB_BRANCH = 3;
  localparam int CB_UNSIGNED_EXT = 2, CB_JUMP = 1, CB_CP0_WRITE = 0;

  localparam logic [12:0] CTRL_MTHILO = 13'h0030, CTRL_MFHILO = 13'h1420, CTRL_MULDIV = 13'h1410;
  localparam logic [12:0] CTRL_JR = 13'h0002, CTRL_JALR = 13'h1602, CTRL_RTYPE = 13'h1400;
  localparam logic [12:0] CTRL_ARITH_IMM = 13'h1100, CTRL_LOGIC_IMM = 13'h1104;
  localparam logic [12:0] CTRL_LOAD = 13'h1140, CTRL_STORE = 13'h0100;
  localparam logic [12:0] CTRL_BRANCH = 13'h0008, CTRL_BRANCH_LINK = 13'h1A08;
  localparam logic [12:0] CTRL_J = 13'h0002, CTRL_JAL = 13'h1A02;
  localparam logic [12:0] CTRL_MFC0 = 13'h1080, CTRL_MTC0 = 13'h0001;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [12:0] ctrl;
    logic        ri;
    logic        syscall;
    logic        brk;
    logic        eret;
    logic        in_ds;
  } entry_t;

endpackage

// File: rtl/ctrl_predecode.sv
// Combinational predecode of one instruction into its control word and exception flags.
module ctrl_predecode import mips_defs_pkg::*; #(
  parameter bit CP0_EN = 1'b1
) (
  input  logic [31:0] instr,
  output logic [12:0] ctrl,
  output logic        ri,
  output logic        syscall,
  output logic        brk,
  output logic        eret,
  output logic        br_or_j
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, sa;
  logic [12:0] raw_ctrl;
  logic        raw_ri;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign sa    = instr[10:6];
  assign funct = instr[5:0];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    raw_ctrl = '0;
    raw_ri   = 1'b0;
    eret     = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_MTHI, FN_MTLO:                     raw_ctrl = CTRL_MTHILO;
          FN_MFHI, FN_MFLO:                     raw_ctrl = CTRL_MFHILO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:   raw_ctrl = CTRL_MULDIV;
          FN_JR:   begin raw_ctrl = CTRL_JR;   raw_ri = |instr[20:6]; end
          FN_JALR: begin raw_ctrl = CTRL_JALR; raw_ri = (rt != '0) || (sa != '0); end
          default:                              raw_ctrl = CTRL_RTYPE;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     raw_ctrl = CTRL_BRANCH;
          RT_BLTZAL, RT_BGEZAL: raw_ctrl = CTRL_BRANCH_LINK;
          default:              raw_ri   = 1'b1;
        endcase
      end
      OP_J:                               raw_ctrl = CTRL_J;
      OP_JAL:                             raw_ctrl = CTRL_JAL;
      OP_BEQ, OP_BNE:                     raw_ctrl = CTRL_BRANCH;
      OP_BLEZ, OP_BGTZ: begin raw_ctrl = CTRL_BRANCH; raw_ri = (rt != '0); end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: raw_ctrl = CTRL_ARITH_IMM;
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:     raw_ctrl = CTRL_LOGIC_IMM;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:  raw_ctrl = CTRL_LOAD;
      OP_SB, OP_SH, OP_SW:                  raw_ctrl = CTRL_STORE;
      OP_COP0: begin
        if (!CP0_EN)                 raw_ri   = 1'b1;
        else if (rs == RS_MF)        raw_ctrl = CTRL_MFC0;
        else if (rs == RS_MT)        raw_ctrl = CTRL_MTC0;
        else if (instr == INSTR_ERET) eret    = 1'b1;
        else                         raw_ri   = 1'b1;
      end
      default: raw_ri = 1'b1;
    endcase
  end

  // A reserved instruction must not cause any architectural side effect downstream.
  assign ctrl    = raw_ri ? '0 : raw_ctrl;
  assign ri      = raw_ri;
  assign syscall = (op == OP_SPECIAL) && (funct == FN_SYSCALL);
  assign brk     = (op == OP_SPECIAL) && (funct == FN_BREAK);
  assign br_or_j = ctrl[CB_BRANCH] | ctrl[CB_JUMP];

endmodule

// File: rtl/predecode_queue.sv
// Fetch-to-decode instruction buffer: predecodes up to IN_WIDTH instructions per push,
// tracks delay slots across pushes, and hands one entry per cycle to decode.
module predecode_queue import mips_defs_pkg::*; #(
  parameter int DEPTH    = 8,
  parameter int IN_WIDTH = 2,
  parameter bit CP0_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [IN_WIDTH-1:0]        in_valid,
  input  logic [32*IN_WIDTH-1:0]     in_instr,
  input  logic [32*IN_WIDTH-1:0]     in_pc,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc,
  output logic [12:0]                out_ctrl,
  output logic                       out_ri,
  output logic                       out_syscall,
  output logic                       out_break,
  output logic                       out_eret,
  output logic                       out_in_ds,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t                     mem [DEPTH];
  entry_t [IN_WIDTH-1:0]      lane_entry;
  logic   [IN_WIDTH-1:0]      lane_br, lane_ds;
  logic   [AW-1:0]            rd_ptr, wr_ptr;
  logic   [CW-1:0]            push_n;
  logic                       last_br, next_last_br, chain_br;
  logic                       push_fire, pop_fire;
  entry_t                     head;

  for (genvar k = 0; k < IN_WIDTH; k++) begin : g_lane
    logic [12:0] ctrl;
    logic        ri, syscall, brk, eret;

    ctrl_predecode #(.CP0_EN(CP0_EN)) u_predecode (
      .instr   (in_instr[32*k +: 32]),
      .ctrl    (ctrl),
      .ri      (ri),
      .syscall (syscall),
      .brk     (brk),
      .eret    (eret),
      .br_or_j (lane_br[k])
    );

    assign lane_entry[k] = '{instr: in_instr[32*k +: 32], pc: in_pc[32*k +: 32], ctrl: ctrl,
                             ri: ri, syscall: syscall, brk: brk, eret: eret, in_ds: lane_ds[k]};
  end

  // Each valid lane inherits branch|jump from the instruction pushed just before it.
  always_comb begin
    chain_br = last_br;
    push_n   = '0;
    lane_ds  = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      lane_ds[k] = chain_br;
      if (in_valid[k]) begin
        chain_br = lane_br[k];
        push_n   = push_n + CW'(1);
      end
    end
    next_last_br = chain_br;
  end

  assign in_ready  = (count <= CW'(DEPTH - IN_WIDTH));
  assign out_valid = (count != '0);
  assign push_fire = in_ready && (|in_valid) && !flush;
  assign pop_fire  = out_valid && out_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      last_br <= 1'b0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      count   <= '0;
      last_br <= 1'b0;
    end else begin
      if (push_fire) begin
        wr_ptr  <= wr_ptr + AW'(push_n);
        last_br <= next_last_br;
      end
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push_fire ? push_n : '0) - CW'(pop_fire);
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count and outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      for (int k = 0; k < IN_WIDTH; k++) begin
        if (in_valid[k]) mem[wr_ptr + AW'(k)] <= lane_entry[k];
      end
    end
  end

  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_ctrl    = head.ctrl;
  assign out_ri      = head.ri;
  assign out_syscall = head.syscall;
  assign out_break   = head.brk;
  assign out_eret    = head.eret;
  assign out_in_ds   = head.in_ds;

endmodule
